// File: rtl/fcart_pkg.sv
// Shared types for the cartridge FIFO-to-memory write path.
// The state encoding is common; sizing parameters stay with each module.
package fcart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      REQ   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_mem_writer.sv
// Drains a show-ahead FIFO into sequential memory words,
// one registered req/ack handshake per word.
module fifo_mem_writer
   import fcart_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 22,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  mem_ack
);

   state_t               state;
   logic [LEN_WIDTH-1:0] remain;
   logic                 abort_pend;

   assign busy = (state != IDLE);

   // An abort in FETCH wins over the pop so no word is lost.
   assign fifo_rd_en = (state == FETCH) && !fifo_empty && !abort;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         done       <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         remain     <= '0;
         abort_pend <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!abort && start) begin
                  if (length == '0) begin
                     done <= 1'b1;
                  end else begin
                     mem_addr   <= base_addr;
                     remain     <= length;
                     abort_pend <= 1'b0;
                     state      <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (abort) begin
                  state <= IDLE;
               end else if (!fifo_empty) begin
                  mem_data <= fifo_data;
                  mem_req  <= 1'b1;
                  state    <= REQ;
               end
            end
            REQ: begin
               // The handshake always finishes; abort only steers what follows.
               if (mem_ack) begin
                  mem_req    <= 1'b0;
                  mem_addr   <= mem_addr + ADDR_WIDTH'(1);
                  remain     <= remain - LEN_WIDTH'(1);
                  abort_pend <= 1'b0;
                  if (abort_pend || abort) begin
                     state <= IDLE;
                  end else if (remain == LEN_WIDTH'(1)) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= FETCH;
                  end
               end else if (abort) begin
                  abort_pend <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fifo_mem_writer.md
FIFO_MEM_WRITER -- requirements
Module: fifo_mem_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, memory/FIFO word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 22, word address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, transfer length width in words.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a transfer.
REQ-007 base_addr  input  ADDR_WIDTH  first word address, sampled with start.
REQ-008 length  input  LEN_WIDTH  word count, sampled with start.
REQ-009 abort  input  1  cancel the current transfer.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse when a transfer completes normally.
REQ-012 fifo_data  input  DATA_WIDTH  show-ahead FIFO read data, valid while fifo_empty is low.
REQ-013 fifo_empty  input  1  FIFO empty flag.
REQ-014 fifo_rd_en  output  1  pops one FIFO word.
REQ-015 mem_req  output  1  write request, registered.
REQ-016 mem_addr  output  ADDR_WIDTH  write address, registered.
REQ-017 mem_data  output  DATA_WIDTH  write data, registered.
REQ-018 mem_ack  input  1  accept; the transfer completes on a cycle where mem_req and mem_ack are both high.

Function
REQ-019 SHALL implement states IDLE, FETCH, REQ and DONE.
REQ-020 IDLE: on start with length != 0, SHALL latch base_addr and length, then enter FETCH.
REQ-021 IDLE: on start with length == 0, SHALL pulse done on the next cycle and remain IDLE.
REQ-022 In IDLE, abort SHALL take priority over a simultaneous start; start is ignored.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 fifo_rd_en SHALL be combinational: high only when state is FETCH and fifo_empty is low; never high in any other state.
REQ-025 FETCH with fifo_empty low SHALL:
- register fifo_data into mem_data;
- set mem_req = 1;
- enter REQ on the next cycle.
REQ-026 FETCH with fifo_empty high SHALL wait indefinitely, with no pop and no request.
REQ-027 In REQ, mem_req, mem_addr and mem_data SHALL stay stable until mem_ack.
REQ-028 On the ack cycle:
- mem_req SHALL be 0 on the next cycle;
- mem_addr SHALL increment by 1, wrapping modulo 2^ADDR_WIDTH;
- the remaining count SHALL decrement.
REQ-029 After the ack cycle, the next state SHALL be DONE if the remaining count was 1, otherwise FETCH.
REQ-030 Minimum throughput with mem_ack held high SHALL be one word per 2 cycles.
REQ-031 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-032 abort in FETCH SHALL return to IDLE on the next cycle without popping.
REQ-033 abort in REQ SHALL be latched and applied after the ack cycle; no handshake is ever truncated.
REQ-034 An aborted transfer SHALL NOT pulse done.
REQ-035 Words already popped SHALL NOT be re-read after an abort.
REQ-036 The remaining counter SHALL be LEN_WIDTH bits, so the maximum transfer is 2^LEN_WIDTH-1 words.

Reset
REQ-037 reset SHALL immediately force:
- state to IDLE;
- busy, done, fifo_rd_en and mem_req to 0;
- mem_addr, mem_data, the remaining counter and the pending-abort flag to 0.
REQ-038 Reset mid-handshake SHALL drop mem_req asynchronously; the memory side is reset by the same reset.

Structure
REQ-039 The state enum typedef SHALL live in the shared package fcart_pkg; parameters stay local.
REQ-040 The design SHALL be a single module with no sub-modules; the FIFO is instantiated by the parent.

Verification
REQ-041 Basic transfer: base_addr=0x100, length=3, FIFO preloaded with A1,B2,C3, mem_ack tied high -> writes (0x100,A1), (0x101,B2), (0x102,C3); done one cycle after the third ack; 3 pops total.
REQ-042 FIFO underrun: length=2, FIFO empty for 10 cycles, then one word, then empty for 5 cycles -> mem_req stays low while the FIFO is empty and fifo_rd_en never fires while it is empty; done after the second write.
REQ-043 Backpressure: mem_ack delayed 4 cycles per word -> mem_addr and mem_data stable during each wait; exactly one pop per write.
REQ-044 Wrap and zero length:
- base_addr=0x3FFFFF, length=2 -> second write to address 0x000000.
- length=0 -> done the next cycle, busy never high.
REQ-045 Abort:
- abort during REQ with ack at +3 cycles -> write completes, then IDLE, no done pulse.
- abort in FETCH -> IDLE the next cycle, no pop.
REQ-046 Reset mid-transfer: assert reset while mem_req=1 -> all outputs 0 immediately; a subsequent start works normally.
